// File: rtl/memory_stage.sv
// MEM stage of the RV32IM pipeline. It issues data-cache accesses and stalls until the response arrives.
// It also aligns load data into the byte/half/word fields and registers the MEM/WB payload.
package memory_stage_pkg;

   typedef struct packed {
      logic       valid;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [2:0] funct3;
      logic [4:0] rd_addr;
   } ctrl_word_t;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] alu_out;
      logic [31:0] rs2_out;
      logic [31:0] mul_out;
      logic [31:0] div_out;
      logic [31:0] cmp_out;
      ctrl_word_t  ctrl_word;
   } ex_mem_reg_t;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] alu_out;
      logic [31:0] mul_out;
      logic [31:0] div_out;
      logic [31:0] cmp_out;
      logic [31:0] lb_out;
      logic [31:0] lbu_out;
      logic [31:0] lh_out;
      logic [31:0] lhu_out;
      logic [31:0] lw_out;
      ctrl_word_t  ctrl_word;
   } mem_wb_reg_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HELD = 2'd2
   } mem_state_e;

   // Access size lives in funct3[1:0]; funct3[2] only selects zero-extension for loads.
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;

endpackage

module memory_stage
   import memory_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  ex_mem_reg_t ex_mem_reg,
   input  logic        stall_in,
   output logic [31:0] dmem_address,
   output logic [3:0]  dmem_rmask,
   output logic [3:0]  dmem_wmask,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic        mem_stall,
   output mem_wb_reg_t mem_wb_reg
);

   mem_state_e  state_q, state_d;
   logic [31:0] rdata_q, rdata_d;
   mem_wb_reg_t mem_wb_q, mem_wb_d;

   logic        mem_op;
   logic        req_active;
   logic        resp_valid;
   logic [1:0]  offset;
   logic [3:0]  lane_mask;
   logic [31:0] lane_wdata;
   logic [31:0] ld;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign mem_op     = ex_mem_reg.ctrl_word.valid &&
                       (ex_mem_reg.ctrl_word.mem_read || ex_mem_reg.ctrl_word.mem_write);
   assign offset     = ex_mem_reg.alu_out[1:0];
   assign req_active = mem_op && (state_q != HELD);
   // A response only counts while a request is actually on the bus.
   assign resp_valid = req_active && dmem_resp;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path through the block can infer a latch.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (dmem_resp) state_d = stall_in ? HELD : IDLE;
               else           state_d = BUSY;
            end
         end
         BUSY: begin
            if (!mem_op)        state_d = IDLE;
            else if (dmem_resp) state_d = stall_in ? HELD : IDLE;
         end
         HELD: begin
            if (!stall_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lane_mask  = 4'b1111;
      lane_wdata = ex_mem_reg.rs2_out;
      case (ex_mem_reg.ctrl_word.funct3[1:0])
         SIZE_BYTE: begin
            lane_mask  = 4'b0001 << offset;
            lane_wdata = {4{ex_mem_reg.rs2_out[7:0]}};
         end
         SIZE_HALF: begin
            lane_mask  = 4'b0011 << {offset[1], 1'b0};
            lane_wdata = {2{ex_mem_reg.rs2_out[15:0]}};
         end
         default: ;
      endcase
   end

   // The request depends on the EX/MEM register and the current state only, so it stays stable while BUSY.
   always_comb begin
      dmem_address = '0;
      dmem_rmask   = '0;
      dmem_wmask   = '0;
      dmem_wdata   = '0;
      if (rst && req_active) begin
         dmem_address = {ex_mem_reg.alu_out[31:2], 2'b00};
         dmem_wdata   = lane_wdata;
         if (ex_mem_reg.ctrl_word.mem_read)  dmem_rmask = lane_mask;
         if (ex_mem_reg.ctrl_word.mem_write) dmem_wmask = lane_mask;
      end
   end

   assign mem_stall = req_active && !dmem_resp;

   assign ld      = resp_valid ? dmem_rdata : rdata_q;
   assign ld_byte = ld[{offset, 3'b000} +: 8];
   assign ld_half = ld[{offset[1], 4'b0000} +: 16];
   assign rdata_d = ld;

   always_comb begin
      mem_wb_d = mem_wb_q;
      if (!stall_in) begin
         mem_wb_d.pc_plus4  = ex_mem_reg.pc_plus4;
         mem_wb_d.alu_out   = ex_mem_reg.alu_out;
         mem_wb_d.mul_out   = ex_mem_reg.mul_out;
         mem_wb_d.div_out   = ex_mem_reg.div_out;
         mem_wb_d.cmp_out   = ex_mem_reg.cmp_out;
         mem_wb_d.ctrl_word = ex_mem_reg.ctrl_word;
         mem_wb_d.lb_out    = {{24{ld_byte[7]}}, ld_byte};
         mem_wb_d.lbu_out   = {24'h0, ld_byte};
         mem_wb_d.lh_out    = {{16{ld_half[15]}}, ld_half};
         mem_wb_d.lhu_out   = {16'h0, ld_half};
         mem_wb_d.lw_out    = ld;
         if (mem_stall) mem_wb_d.ctrl_word.valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_q  <= '0;
         mem_wb_q <= '0;
      end else begin
         rdata_q  <= rdata_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   assign mem_wb_reg = mem_wb_q;

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the RV32IM core, between the EX/MEM register and `writeback_stage`. Issues loads and stores from `ex_mem_reg` to the data cache with a hold-until-response handshake and stalls the pipeline while a data access is outstanding. Aligns returned data into the `lb_out`, `lbu_out`, `lh_out`, `lhu_out` and `lw_out` fields. Owns and registers `mem_wb_reg`, which `writeback_stage` consumes.

## Interface
- No parameters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `ex_mem_reg`  in  ex_mem_reg_t  EX/MEM register. Fields used:
  - `ctrl_word.valid`, `ctrl_word.mem_read`, `ctrl_word.mem_write`, `ctrl_word.funct3`.
  - `alu_out`: effective address.
  - `rs2_out`: store data.
- `stall_in`  in  1  global freeze from the hazard unit (e.g. icache miss). All pipeline registers hold.
- `dmem_address`  out  32  word-aligned address `{alu_out[31:2],2'b00}`.
- `dmem_rmask`  out  4  byte read enables; nonzero means a read request.
- `dmem_wmask`  out  4  byte write enables; nonzero means a write request.
- `dmem_wdata`  out  32  store data, lane-shifted.
- `dmem_rdata`  in  32  read data; valid when `dmem_resp`=1.
- `dmem_resp`  in  1  access complete; valid for one cycle.
- `mem_stall`  out  1  data access outstanding; EX/MEM and all earlier stages must hold.
- `mem_wb_reg`  out  mem_wb_reg_t  registered MEM/WB payload.

## Operation
- A memory op is `ctrl_word.valid` && (`mem_read` || `mem_write`).
- FSM states:
  - IDLE: request driven for any memory op. On `dmem_resp`: if `stall_in`=1 go HELD, otherwise stay IDLE. With no resp, go BUSY.
  - BUSY: request held stable. On `dmem_resp`: if `stall_in`=1 go HELD, otherwise go IDLE.
  - HELD: request deasserted, data kept in `rdata_q`. Go IDLE on the first cycle with `stall_in`=0; EX/MEM advances at the same edge.
- Request outputs are combinational from `ex_mem_reg`. They are all-zero in HELD, for non-memory ops, and while `rst`=0.
- Masks by `funct3` and offset `o = alu_out[1:0]`:
  - byte: `4'b0001<<o`.
  - half: `4'b0011<<{o[1],1'b0}`; `o[0]` ignored.
  - word: `4'b1111`; `o` ignored.
  - Misaligned accesses are never trapped.
- `dmem_wdata`: byte stores replicate `rs2_out[7:0]` on all lanes. Half stores replicate `rs2_out[15:0]`. Word stores pass `rs2_out` unchanged.
- Load source `ld`: `dmem_rdata` when `dmem_resp`=1, otherwise `rdata_q`.
  - `lb_out`/`lbu_out`: byte `ld[8o+:8]`, sign- or zero-extended.
  - `lh_out`/`lhu_out`: half `ld[16o[1]+:16]`, sign- or zero-extended.
  - `lw_out` = `ld`.
  - All five fields are always computed, whatever the `funct3`.
- `mem_stall` = memory op && state != HELD && !`dmem_resp`.
- `mem_wb_reg` update, in priority order:
  - `stall_in`=1: hold.
  - else `mem_stall`=1: load a bubble; all fields copied, `ctrl_word.valid`=0.
  - else: load `ex_mem_reg` pass-through fields (`pc_plus4`, `alu_out`, mul/div/cmp results, `ctrl_word`) plus the five load fields.
- `rdata_q` captures `dmem_rdata` whenever `dmem_resp`=1.
- `dmem_resp` in HELD or with no request outstanding is ignored.

## Timing
- Reset (`rst`=0 at an edge):
  - state = IDLE; `mem_wb_reg` = all zeros (valid=0); `rdata_q` = 0.
  - Reset mid-access abandons the request; request outputs are 0 in the following cycle.
- Same-cycle response: a load gets `dmem_resp` in its first MEM cycle. `mem_stall`=0 and the result is in `mem_wb_reg` after 1 edge, with no bubble.
- N-cycle response (resp N cycles after the request first appears): `mem_stall` is high for N cycles. Exactly N bubbles enter MEM/WB, then the instruction.
- Back-to-back memory ops: the request for the next op appears in the cycle after the response with no gap. Request outputs never glitch to zero between consecutive ops except through HELD.
- Response coinciding with `stall_in`: data is retained in `rdata_q` with no re-issue. The instruction commits on the edge where `stall_in` falls.
- Non-memory ops: zero added latency.

## Test plan
- Same-cycle response:
  - Stimulus: lw, addr 0x100, `dmem_rdata`=0xDEADBEEF, resp in the same cycle.
  - Required: `dmem_rmask`=1111, `mem_stall` never asserted, `mem_wb_reg.lw_out`=0xDEADBEEF with valid=1 after 1 edge.
- Byte and half loads:
  - Stimulus: `dmem_rdata`=0x80FF7F01 with lb at addr 0x103, lbu at 0x103, lh at 0x102, lhu at 0x102.
  - Required: `lb_out`=0xFFFFFF80; `lbu_out`=0x00000080; `lh_out`=0xFFFF80FF; `lhu_out`=0x000080FF. Masks 1000 / 1000 / 1100 / 1100.
- Stores:
  - Stimulus: sb of `rs2_out`=0x123456AB at addr 0x201; sh at 0x202.
  - Required: sb gives `wmask`=0010, `wdata`=0xABABABAB; sh gives `wmask`=1100, `wdata`=0x56AB56AB.
- Three-cycle latency:
  - Stimulus: resp arrives 3 cycles after the request.
  - Required: `mem_stall` high for 3 cycles, 3 bubbles (valid=0) enter MEM/WB, request fields stable throughout.
- Response during freeze:
  - Stimulus: resp arrives while `stall_in`=1, which stays high 4 more cycles.
  - Required: FSM in HELD, request outputs 0, `mem_wb_reg` held, no second request. The load commits with the correct data on the edge where `stall_in` falls.
- Reset mid-access:
  - Stimulus: `rst`=0 while in BUSY.
  - Required: next cycle shows state IDLE, request outputs 0, `mem_wb_reg`=0.
